multi_alarm_clock: RTL and testbench

MULTI_ALARM_CLOCK -- requirements
Module: multi_alarm_clock

---
 rtl/multi_alarm_clock.sv | 223 ++++++++++++++++++++++
 tb/tb_multi_alarm_clock.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock
//   24-hour time-of-day clock with NUM_ALARMS independent alarm channels.
//   A prescaler derives a one-second tick from clk. Three pulse buttons
//   drive a two-level mode FSM used to set the time and program the alarms.
//
// Ports
//   clk            in   system clock and time base
//   reset_n        in   asynchronous active-low master reset
//   sw1            in   pulse: toggle major mode TIME/ALARM (minor mode -> 0)
//   sw2            in   pulse: advance minor mode
//   set            in   pulse: increment / toggle / dismiss ringing alarms
//   mode1          out  major mode, 0=TIME 1=ALARM
//   mode2          out  minor mode
//   out_h/m/s      out  registered binary display values
//   alarm          out  OR of all ringing channels
//   ring           out  per-channel ringing flags
//
// state   | meaning
// S_GEN   | TIME: show time, set has no effect
// S_HOUR  | TIME: set increments hours
// S_MIN   | TIME: set increments minutes (no carry)
// S_SEC   | TIME: set clears seconds and prescaler
// S_VIEW  | ALARM: set selects next channel
// S_AHOUR | ALARM: set increments alarm hour of selected channel
// S_AMIN  | ALARM: set increments alarm minute of selected channel
// S_AEN   | ALARM: set toggles enable of selected channel
module multi_alarm_clock #(
  parameter int CLOCKS4SEC = 100,
  parameter int NUM_ALARMS = 4,
  parameter int RING_SECS  = 60
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sw1,
  input  logic                  sw2,
  input  logic                  set,
  output logic                  mode1,
  output logic [1:0]            mode2,
  output logic [5:0]            out_h,
  output logic [5:0]            out_m,
  output logic [5:0]            out_s,
  output logic                  alarm,
  output logic [NUM_ALARMS-1:0] ring
);

  localparam int PW = (CLOCKS4SEC > 1) ? $clog2(CLOCKS4SEC) : 1;
  localparam int SW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLOCKS4SEC - 1);
  localparam logic [SW-1:0] SEL_MAX   = SW'(NUM_ALARMS - 1);
  localparam logic [5:0]    RING_LOAD = 6'(RING_SECS);

  // Encoding is {mode1, mode2} so the outputs are plain register slices.
  typedef enum logic [2:0] {
    S_GEN   = 3'd0, S_HOUR = 3'd1, S_MIN  = 3'd2, S_SEC = 3'd3,
    S_VIEW  = 3'd4, S_AHOUR = 3'd5, S_AMIN = 3'd6, S_AEN = 3'd7
  } state_t;

  state_t                r_state, w_state_nx;
  logic [PW-1:0]         r_presc, w_presc_nx;
  logic [5:0]            r_hours, r_mins, r_secs;
  logic [5:0]            w_hours_nx, w_mins_nx, w_secs_nx;
  logic [5:0]            r_alarm_h [NUM_ALARMS];
  logic [5:0]            r_alarm_m [NUM_ALARMS];
  logic [5:0]            r_rcnt    [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] r_en, r_ring, w_match, w_en_clr;
  logic [SW-1:0]         r_sel;
  logic [5:0]            r_out_h, r_out_m, r_out_s;
  logic                  w_tick, w_set_act, w_dismiss;
  logic                  w_do_hour, w_do_min, w_do_sec;
  logic                  w_do_view, w_do_ahour, w_do_amin, w_do_aen;
  logic                  w_sec_carry, w_min_carry;

  function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] max);
    return (v == max) ? 6'd0 : v + 6'd1;
  endfunction

  assign mode1 = r_state[2];
  assign mode2 = r_state[1:0];
  assign out_h = r_out_h;
  assign out_m = r_out_m;
  assign out_s = r_out_s;
  assign ring  = r_ring;
  assign alarm = |r_ring;

  // A set while anything rings is a dismiss and nothing else.
  assign w_set_act = set & ~alarm;
  assign w_dismiss = set & alarm;
  assign w_tick    = (r_presc == PRESC_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_GEN;
    else          r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_do_hour  = 1'b0;
    w_do_min   = 1'b0;
    w_do_sec   = 1'b0;
    w_do_view  = 1'b0;
    w_do_ahour = 1'b0;
    w_do_amin  = 1'b0;
    w_do_aen   = 1'b0;
    if (sw1) begin
      w_state_nx = r_state[2] ? S_GEN : S_VIEW;
    end else if (sw2) begin
      case (r_state)
        S_GEN:   w_state_nx = S_HOUR;
        S_HOUR:  w_state_nx = S_MIN;
        S_MIN:   w_state_nx = S_SEC;
        S_SEC:   w_state_nx = S_GEN;
        S_VIEW:  w_state_nx = S_AHOUR;
        S_AHOUR: w_state_nx = S_AMIN;
        S_AMIN:  w_state_nx = S_AEN;
        default: w_state_nx = S_VIEW;
      endcase
    end
    case (r_state)
      S_HOUR:  w_do_hour  = w_set_act;
      S_MIN:   w_do_min   = w_set_act;
      S_SEC:   w_do_sec   = w_set_act;
      S_VIEW:  w_do_view  = w_set_act;
      S_AHOUR: w_do_ahour = w_set_act;
      S_AMIN:  w_do_amin  = w_set_act;
      S_AEN:   w_do_aen   = w_set_act;
      default: ;
    endcase
  end

  // A user edit of a field takes precedence over a carry into it; the
  // carry out of an edited field is suppressed.
  always_comb begin
    w_presc_nx  = (w_do_sec || w_tick) ? '0 : r_presc + 1'b1;
    w_sec_carry = w_tick && (r_secs == 6'd59) && !w_do_sec;
    w_min_carry = w_sec_carry && (r_mins == 6'd59) && !w_do_min;
    w_secs_nx   = r_secs;
    w_mins_nx   = r_mins;
    w_hours_nx  = r_hours;
    if (w_do_sec)         w_secs_nx = 6'd0;
    else if (w_tick)      w_secs_nx = inc_wrap(r_secs, 6'd59);
    if (w_do_min || w_sec_carry)  w_mins_nx  = inc_wrap(r_mins, 6'd59);
    if (w_do_hour || w_min_carry) w_hours_nx = inc_wrap(r_hours, 6'd23);
  end

  // Matching is against the time the tick produces, so ring rises together
  // with the seconds rolling to zero.
  always_comb begin
    w_match  = '0;
    w_en_clr = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      w_match[i]  = w_tick && (w_secs_nx == 6'd0) && r_en[i] &&
                    (w_hours_nx == r_alarm_h[i]) && (w_mins_nx == r_alarm_m[i]);
      w_en_clr[i] = w_do_aen && (r_sel == SW'(i)) && r_en[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_hours <= 6'd0;
      r_mins  <= 6'd0;
      r_secs  <= 6'd0;
    end else begin
      r_presc <= w_presc_nx;
      r_hours <= w_hours_nx;
      r_mins  <= w_mins_nx;
      r_secs  <= w_secs_nx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sel <= '0;
      r_en  <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        r_alarm_h[i] <= 6'd0;
        r_alarm_m[i] <= 6'd0;
      end
    end else begin
      if (w_do_view)  r_sel <= (r_sel == SEL_MAX) ? '0 : r_sel + 1'b1;
      if (w_do_ahour) r_alarm_h[r_sel] <= inc_wrap(r_alarm_h[r_sel], 6'd23);
      if (w_do_amin)  r_alarm_m[r_sel] <= inc_wrap(r_alarm_m[r_sel], 6'd59);
      if (w_do_aen)   r_en[r_sel] <= ~r_en[r_sel];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ring <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) r_rcnt[i] <= 6'd0;
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (w_dismiss || w_en_clr[i]) begin
          r_ring[i] <= 1'b0;
          r_rcnt[i] <= 6'd0;
        end else if (w_match[i]) begin
          r_ring[i] <= 1'b1;
          r_rcnt[i] <= RING_LOAD;
        end else if (r_ring[i] && w_tick) begin
          r_rcnt[i] <= r_rcnt[i] - 6'd1;
          if (r_rcnt[i] == 6'd1) r_ring[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_h <= 6'd0;
      r_out_m <= 6'd0;
      r_out_s <= 6'd0;
    end else if (r_state[2]) begin
      r_out_h <= r_alarm_h[r_sel];
      r_out_m <= r_alarm_m[r_sel];
      r_out_s <= r_en[r_sel] ? 6'(r_sel) + 6'd1 : 6'd0;
    end else begin
      r_out_h <= r_hours;
      r_out_m <= r_mins;
      r_out_s <= r_secs;
    end
  end

endmodule

// File: tb/tb_multi_alarm_clock.sv
module tb_multi_alarm_clock;

  localparam int NA = 4;
  localparam int O_MODE1 = 0, O_MODE2 = 1, O_H = 2, O_M = 3, O_S = 4, O_ALARM = 5, O_RING = 6;

  logic          clk = 1'b0;
  logic          reset_n, sw1, sw2, set;
  logic          mode1;
  logic [1:0]    mode2;
  logic [5:0]    out_h, out_m, out_s;
  logic          alarm;
  logic [NA-1:0] ring;

  multi_alarm_clock #(.CLOCKS4SEC(4), .NUM_ALARMS(NA), .RING_SECS(3)) dut (
    .clk(clk), .reset_n(reset_n), .sw1(sw1), .sw2(sw2), .set(set),
    .mode1(mode1), .mode2(mode2), .out_h(out_h), .out_m(out_m), .out_s(out_s),
    .alarm(alarm), .ring(ring)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] exp;
    int         due;
  } sb_t;

  sb_t sb[$];
  int  cyc_n = 0;
  int  total = 0;
  int  bad   = 0;

  function automatic logic [7:0] observe(input int sel);
    case (sel)
      O_MODE1: return {7'd0, mode1};
      O_MODE2: return {6'd0, mode2};
      O_H:     return {2'd0, out_h};
      O_M:     return {2'd0, out_m};
      O_S:     return {2'd0, out_s};
      O_ALARM: return {7'd0, alarm};
      O_RING:  return {4'd0, ring};
      default: return 8'hxx;
    endcase
  endfunction

  task automatic compare(input sb_t e);
    logic [7:0] obs;
    obs = observe(e.sel);
    total++;
    assert (obs === e.exp) else begin
      bad++;
      $error("FAIL %s at cycle %0d: observed=%0d expected=%0d", e.tag, cyc_n, obs, e.exp);
    end
  endtask

  task automatic expect_at(input string tag, input int sel, input int exp, input int lat);
    sb_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = 8'(exp);
    e.due = cyc_n + lat;
    sb.push_back(e);
  endtask

  task automatic drain();
    sb_t keep[$];
    for (int k = 0; k < sb.size(); k++) begin
      if (sb[k].due <= cyc_n) compare(sb[k]);
      else keep.push_back(sb[k]);
    end
    sb = keep;
  endtask

  task automatic now_chk(input string tag, input int sel, input int exp);
    expect_at(tag, sel, exp, 0);
    drain();
  endtask

  // One clock: inputs held across a single rising edge, outputs sampled on
  // the following falling edge.
  task automatic cyc(input logic a, input logic b, input logic c);
    sw1 = a;
    sw2 = b;
    set = c;
    @(posedge clk);
    #1;
    sw1 = 1'b0;
    sw2 = 1'b0;
    set = 1'b0;
    @(negedge clk);
    cyc_n++;
    drain();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic sets(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    sw1 = 1'b0;
    sw2 = 1'b0;
    set = 1'b0;
    repeat (2) @(negedge clk);
    now_chk("rst_mode1", O_MODE1, 0);
    now_chk("rst_mode2", O_MODE2, 0);
    now_chk("rst_h", O_H, 0);
    now_chk("rst_m", O_M, 0);
    now_chk("rst_s", O_S, 0);
    now_chk("rst_alarm", O_ALARM, 0);
    now_chk("rst_ring", O_RING, 0);
    reset_n = 1'b1;

    // Set 23:59:59 and roll over to midnight
    expect_at("mode_hour", O_MODE2, 1, 1);
    cyc(0, 1, 0);                       // 1   HOUR
    sets(23);                           // 24
    expect_at("hours_23", O_H, 23, 1);
    cyc(0, 1, 0);                       // 25  MIN
    sets(59);                           // 84
    cyc(0, 1, 0);                       // 85  SEC
    expect_at("sec_clear", O_S, 0, 2);
    expect_at("sec_hold", O_S, 0, 5);
    expect_at("sec_tick4", O_S, 1, 6);
    cyc(0, 0, 1);                       // 86  secs=0, prescaler=0
    idle(236);                          // 322 23:59:59
    expect_at("h_235959", O_H, 23, 1);
    expect_at("m_235959", O_M, 59, 1);
    expect_at("s_235959", O_S, 59, 1);
    expect_at("s_before_roll", O_S, 59, 4);
    expect_at("h_roll", O_H, 0, 5);
    expect_at("m_roll", O_M, 0, 5);
    expect_at("s_roll", O_S, 0, 5);
    expect_at("no_alarm_roll", O_ALARM, 0, 5);
    expect_at("no_ring_roll", O_RING, 0, 5);
    idle(5);                            // 327

    // ALARM VIEW selection wrap, enable channel 1
    expect_at("alarm_mode1", O_MODE1, 1, 1);
    expect_at("alarm_mode2", O_MODE2, 0, 1);
    cyc(1, 0, 0);                       // 328 VIEW
    for (int k = 0; k < 5; k++) begin
      expect_at("view_dis_s", O_S, 0, 2);
      cyc(0, 0, 1);                     // 329..333 sel 1,2,3,0,1
    end
    cyc(0, 1, 0);                       // 334 AHOUR
    cyc(0, 1, 0);                       // 335 AMIN
    expect_at("mode_aen", O_MODE2, 3, 1);
    cyc(0, 1, 0);                       // 336 AEN
    expect_at("en_sel1_s", O_S, 2, 2);
    cyc(0, 0, 1);                       // 337 en[1]=1

    // Channel 2 at 00:01
    cyc(0, 1, 0);                       // 338 VIEW
    cyc(0, 0, 1);                       // 339 sel=2
    cyc(0, 1, 0);                       // 340 AHOUR
    cyc(0, 1, 0);                       // 341 AMIN
    cyc(0, 0, 1);                       // 342 alarm_m[2]=1
    cyc(0, 1, 0);                       // 343 AEN
    expect_at("ch2_m", O_M, 1, 2);
    expect_at("ch2_s", O_S, 3, 2);
    cyc(0, 0, 1);                       // 344 en[2]=1
    cyc(1, 0, 0);                       // 345 TIME GEN
    cyc(0, 1, 0);                       // 346 HOUR
    cyc(0, 1, 0);                       // 347 MIN
    cyc(0, 1, 0);                       // 348 SEC
    cyc(0, 0, 1);                       // 349 00:00:00, prescaler=0
    expect_at("ch2_pre_ring", O_RING, 0, 239);
    expect_at("ch2_ring", O_RING, 4'b0100, 240);
    expect_at("ch2_alarm", O_ALARM, 1, 240);
    expect_at("ch2_time_m", O_M, 1, 241);
    expect_at("ch2_still", O_RING, 4'b0100, 251);
    expect_at("ch2_selfclr", O_RING, 0, 252);
    expect_at("ch2_alarm_off", O_ALARM, 0, 252);
    idle(252);                          // 601

    // Channels 0 and 3 at 01:00, then dismiss
    cyc(1, 0, 0);                       // 602 VIEW (sel=2 kept)
    cyc(0, 0, 1);                       // 603 sel=3
    cyc(0, 1, 0);                       // 604 AHOUR
    cyc(0, 0, 1);                       // 605 alarm_h[3]=1
    cyc(0, 1, 0);                       // 606 AMIN
    cyc(0, 1, 0);                       // 607 AEN
    expect_at("ch3_h", O_H, 1, 2);
    expect_at("ch3_s", O_S, 4, 2);
    cyc(0, 0, 1);                       // 608 en[3]=1
    cyc(0, 1, 0);                       // 609 VIEW
    cyc(0, 0, 1);                       // 610 sel=0
    cyc(0, 1, 0);                       // 611 AHOUR
    cyc(0, 0, 1);                       // 612 alarm_h[0]=1
    cyc(0, 1, 0);                       // 613 AMIN
    cyc(0, 1, 0);                       // 614 AEN
    cyc(0, 0, 1);                       // 615 en[0]=1
    cyc(1, 0, 0);                       // 616 TIME GEN
    cyc(0, 1, 0);                       // 617 HOUR
    cyc(0, 1, 0);                       // 618 MIN
    sets(58);                           // 676 mins=59
    cyc(0, 1, 0);                       // 677 SEC
    cyc(0, 0, 1);                       // 678 00:59:00
    expect_at("dual_pre", O_RING, 0, 239);
    expect_at("dual_ring", O_RING, 4'b1001, 240);
    expect_at("dual_alarm", O_ALARM, 1, 240);
    idle(240);                          // 918 01:00:00
    expect_at("dismiss_ring", O_RING, 0, 1);
    expect_at("dismiss_alarm", O_ALARM, 0, 1);
    expect_at("dismiss_h", O_H, 1, 2);
    expect_at("dismiss_m", O_M, 0, 2);
    expect_at("dismiss_no_secclr", O_S, 1, 5);
    cyc(0, 0, 1);                       // 919 dismiss only
    idle(4);                            // 923
    expect_at("ah0_kept", O_H, 1, 2);
    expect_at("en0_kept", O_S, 1, 2);
    cyc(1, 0, 0);                       // 924 VIEW sel=0

    // Hour set colliding with the 59:59 carry
    cyc(1, 0, 0);                       // 925 TIME GEN
    cyc(0, 1, 0);                       // 926 HOUR
    cyc(0, 1, 0);                       // 927 MIN
    sets(59);                           // 986 mins=59
    cyc(0, 1, 0);                       // 987 SEC
    cyc(0, 0, 1);                       // 988 01:59:00
    cyc(0, 1, 0);                       // 989 GEN
    cyc(0, 1, 0);                       // 990 HOUR
    idle(237);                          // 1227 01:59:59
    expect_at("coll_h", O_H, 2, 2);
    expect_at("coll_m", O_M, 0, 2);
    expect_at("coll_s", O_S, 0, 2);
    expect_at("coll_alarm", O_ALARM, 0, 1);
    cyc(0, 0, 1);                       // 1228 set + carry -> 02:00:00

    // sw1 beats sw2
    expect_at("sw1_wins_m1", O_MODE1, 1, 1);
    expect_at("sw1_wins_m2", O_MODE2, 0, 1);
    cyc(1, 1, 0);                       // 1229 VIEW

    // Channel 1 at 02:01, reset while ringing
    cyc(0, 0, 1);                       // 1230 sel=1
    cyc(0, 1, 0);                       // 1231 AHOUR
    sets(2);                            // 1233 alarm_h[1]=2
    cyc(0, 1, 0);                       // 1234 AMIN
    cyc(0, 0, 1);                       // 1235 alarm_m[1]=1
    cyc(0, 1, 0);                       // 1236 AEN
    expect_at("ch1_pre", O_RING, 0, 231);
    expect_at("ch1_ring", O_RING, 4'b0010, 232);
    expect_at("ch1_view_h", O_H, 2, 232);
    expect_at("ch1_view_s", O_S, 2, 232);
    idle(232);                          // 1468
    #2;
    reset_n = 1'b0;
    #1;
    now_chk("async_ring", O_RING, 0);
    now_chk("async_alarm", O_ALARM, 0);
    now_chk("async_mode1", O_MODE1, 0);
    now_chk("async_mode2", O_MODE2, 0);
    now_chk("async_h", O_H, 0);
    now_chk("async_m", O_M, 0);
    now_chk("async_s", O_S, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    expect_at("first_tick_pre", O_S, 0, 4);
    expect_at("first_tick", O_S, 1, 5);
    expect_at("post_rst_ring", O_RING, 0, 5);
    expect_at("post_rst_alarm", O_ALARM, 0, 5);
    idle(5);

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drain: observed=%0d pending expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
